// File: rtl/bcd_seven_seg_driver.sv
// bcd_seven_seg_driver
//   Shows an 8-bit binary count (0..255) as a 3-digit decimal number on a
//   multiplexed, active-low 7-segment display. The count comes from a slow
//   clock domain. It is synchronized here and checked for stability. It is
//   then converted to BCD with a sequential double-dabble, one bit per cycle.
//
//   Ports
//     CLK100MHZ  in   system clock, the only clock
//     reset      in   synchronous, active-high reset
//     value      in   [7:0]  binary count, asynchronous to CLK100MHZ
//     AN         out  [7:0]  digit anodes, active low (AN[0]=ones .. AN[2]=hundreds)
//     SEG        out  [6:0]  segments a..g, active low
//     DP         out  decimal point, active low, held off
//     bcd        out  [11:0] last converted value {hundreds,tens,ones}
//     busy       out  high while a conversion is running
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a stable input that differs from the last conversion
//   SHIFT | 8 double-dabble steps: add 3 to nibbles >= 5, then shift left
//   LOAD  | publish the accumulator to bcd
module bcd_seven_seg_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]    s1, s2, s3, last_conv;
  logic [7:0]    bin_sr;
  logic [11:0]   bcd_acc, bcd_adj;
  logic [3:0]    shift_cnt;
  logic          start;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // A start needs the synchronized value to have held for a cycle, so a
  // value that moves every cycle can never trigger a conversion.
  assign start = (s2 == s3) && (s2 != last_conv);

  assign bcd_adj = {add3(bcd_acc[11:8]), add3(bcd_acc[7:4]), add3(bcd_acc[3:0])};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (shift_cnt == 4'd7) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      s1        <= 8'd0;
      s2        <= 8'd0;
      s3        <= 8'd0;
      last_conv <= 8'd0;
      bin_sr    <= 8'd0;
      bcd_acc   <= 12'd0;
      shift_cnt <= 4'd0;
      bcd       <= 12'd0;
      busy      <= 1'b0;
    end else begin
      s1   <= value;
      s2   <= s1;
      s3   <= s2;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr    <= s2;
            last_conv <= s2;
            bcd_acc   <= 12'd0;
            shift_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          {bcd_acc, bin_sr} <= {bcd_adj, bin_sr} << 1;
          shift_cnt         <= shift_cnt + 4'd1;
        end
        LOAD:    bcd <= bcd_acc;
        default: ;
      endcase
    end
  end

  // The display follows bcd on every cycle, so a new result shows up one
  // cycle later, even if it lands in the middle of a digit slot.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (digit_idx)
      2'd0: nib = bcd[3:0];
      2'd1: begin
        nib   = bcd[7:4];
        blank = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0);
      end
      default: blank = 1'b1;
    endcase
    an_next  = blank ? 8'hFF : ~(8'b1 << digit_idx);
    seg_next = blank ? 7'h7F : seg_pat(nib);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      AN          <= 8'hFF;
      SEG         <= 7'h7F;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// tb_bcd_seven_seg_driver
//   Directed bench for bcd_seven_seg_driver with REFRESH_DIV=4 and
//   BLANK_LZ=1. Inputs change on the falling edge, and outputs are
//   sampled on the falling edge.
module tb_bcd_seven_seg_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] bcd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;

  always #5 clk = ~clk;

  bcd_seven_seg_driver #(
    .REFRESH_DIV(4),
    .BLANK_LZ   (1)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .value    (value),
    .AN       (an),
    .SEG      (seg),
    .DP       (dp),
    .bcd      (bcd),
    .busy     (busy)
  );

  // Counts the clock edges since reset was released. The edge count tells
  // which slot is showing: digit floor((n-1)/4) mod 3.
  always @(posedge clk) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int k;
    k = 0;
    while (busy !== lvl && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string tag);
    value = v;
    wait_busy(1'b1, {tag, "_busy_rise"});
    wait_busy(1'b0, {tag, "_busy_fall"});
    check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp});
  endtask

  // e_an / e_seg pack the expected pattern per slot: {hundreds, tens, ones}.
  task automatic check_frame(input logic [23:0] e_an, input logic [20:0] e_seg, input string tag);
    int slot;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      slot = ((ncyc - 1) / 4) % 3;
      check({tag, "_an"},  {24'd0, an},  {24'd0, e_an[slot*8 +: 8]});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, e_seg[slot*7 +: 7]});
    end
    check({tag, "_dp"}, {31'd0, dp}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_len;
    int busy_seen;

    // 1. reset state and first display cycle
    value = 8'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an",   {24'd0, an},  32'hFF);
    check("rst_seg",  {25'd0, seg}, 32'h7F);
    check("rst_dp",   {31'd0, dp},  32'd1);
    check("rst_bcd",  {20'd0, bcd}, 32'h000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_an",  {24'd0, an},  32'hFE);
    check("first_seg", {25'd0, seg}, 32'h40);

    // 2. max value: 9 busy cycles, then 255, all digits lit
    value = 8'd255;
    wait_busy(1'b1, "v255_busy_rise");
    busy_len = 0;
    while (busy === 1'b1 && busy_len < 30) begin
      busy_len++;
      @(negedge clk);
    end
    check("v255_busy_len", busy_len, 32'd9);
    check("v255_bcd", {20'd0, bcd}, 32'h255);
    check_frame({8'hFB, 8'hFD, 8'hFE}, {7'h24, 7'h12, 7'h12}, "v255_scan");

    // 3. single digit: tens and hundreds blanked
    convert(8'd7, 12'h007, "v7");
    check_frame({8'hFF, 8'hFF, 8'hFE}, {7'h7F, 7'h7F, 7'h78}, "v7_scan");

    // 4. input change during a conversion is picked up afterwards
    value = 8'd42;
    wait_busy(1'b1, "v42_busy_rise");
    repeat (2) @(negedge clk);
    value = 8'd100;
    wait_busy(1'b0, "v42_busy_fall");
    check("v42_bcd", {20'd0, bcd}, 32'h042);
    wait_busy(1'b1, "v100_busy_rise");
    wait_busy(1'b0, "v100_busy_fall");
    check("v100_bcd", {20'd0, bcd}, 32'h100);

    // 5. input toggling every cycle never starts a conversion
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
      value = (i % 2 == 1) ? 8'hAA : 8'h55;
    end
    check("toggle_busy", busy_seen, 32'd0);
    check("toggle_bcd", {20'd0, bcd}, 32'h100);
    convert(8'hAA, 12'h170, "vAA");

    // 6. reset in the middle of SHIFT discards the conversion
    value = 8'd200;
    wait_busy(1'b1, "v200_busy_rise");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_bcd",  {20'd0, bcd},  32'h000);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_an",   {24'd0, an},   32'hFF);
    reset = 1'b0;
    wait_busy(1'b1, "v200b_busy_rise");
    wait_busy(1'b0, "v200b_busy_fall");
    check("v200b_bcd", {20'd0, bcd}, 32'h200);
    check_frame({8'hFB, 8'hFD, 8'hFE}, {7'h24, 7'h40, 7'h40}, "v200_scan");
    convert(8'd255, 12'h255, "wrap255");
    convert(8'd0,   12'h000, "wrap0");
    check_frame({8'hFF, 8'hFF, 8'hFE}, {7'h7F, 7'h7F, 7'h40}, "v0_scan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
